// File: rtl/sift_dir_pkg.sv
// Shared constants and types for the SIFT orientation lookup path.
// Latency: none (declarations only).
// Backpressure: n/a.
package sift_dir_pkg;

  localparam int DIR_AW   = 8;  // {dy,dx} quantized gradient address
  localparam int DIR_DW   = 5;  // orientation bin 0..31
  localparam int DIR_NREQ = 4;  // descriptor-histogram requesters sharing the LUT

  typedef logic [DIR_DW-1:0] dir_bin_t;

endpackage

// File: rtl/dir_lut_arb_rr_pick.sv
// Round-robin pick: first set bit of the eligible mask at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; callers mask out ineligible requesters before the pick.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] elig,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx,
  output logic            gnt_any
);

  logic [2*NREQ-1:0] dbl;
  logic [2*NREQ-1:0] masked;

  // Double the mask so the wrap-around becomes a plain lowest-bit search above ptr.
  always_comb begin
    dbl     = {elig, elig};
    masked  = '0;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = 0; i < 2*NREQ; i++) begin
      masked[i] = dbl[i] && (i >= int'(ptr));
    end
    // Scan downward so the lowest set position is the one left standing.
    for (int i = 2*NREQ-1; i >= 0; i--) begin
      if (masked[i]) begin
        gnt_idx = PW'((i >= NREQ) ? (i - NREQ) : i);
        gnt_any = 1'b1;
      end
    end
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/dir_lut_arb.sv
// Round-robin sharing of one combinational orientation LUT among NREQ requesters.
// Latency: grant same cycle as req_valid, result in the per-requester slot 1 cycle later.
// Backpressure: a requester is only granted when its slot is empty or draining this cycle.
module dir_lut_arb
  import sift_dir_pkg::*;
#(
  parameter int NREQ = DIR_NREQ,
  parameter int AW   = DIR_AW,
  parameter int DW   = DIR_DW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [NREQ*DW-1:0] rsp_data,
  input  logic [NREQ-1:0]    rsp_ready,
  output logic [AW-1:0]      lut_addr,
  input  logic [DW-1:0]      lut_dout,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nxt;
  logic [NREQ-1:0] slot_free;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_any;

  // A draining slot is free; reset is folded in so no grant leaks out while held.
  assign slot_free = ~rsp_valid | rsp_ready;
  assign elig      = req_valid & slot_free & {NREQ{rst_n}};
  assign req_ready = gnt;
  assign busy      = (|req_valid) | (|rsp_valid);

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .elig    (elig),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Steer the granted address to the LUT; park at zero when idle.
  always_comb begin
    lut_addr = '0;
    ptr_nxt  = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    if (gnt_any) begin
      lut_addr = req_addr[gnt_idx*AW +: AW];
    end
  end

  // Pointer advances past the winner; slots load on grant, otherwise clear on consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      if (gnt_any) begin
        ptr <= ptr_nxt;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) begin
          rsp_valid[i]          <= 1'b1;
          rsp_data[i*DW +: DW]  <= lut_dout;
        end else if (rsp_ready[i]) begin
          rsp_valid[i]          <= 1'b0;
        end
      end
    end
  end

endmodule
